tohost_monitor: RTL
===================

Name: tohost_monitor

Overview:
- Synthesizable simulation-end and compliance-result monitor that taps the data-memory store port of cpu_top, directly downstream of the core's load/store path.
- Decodes stores to the riscv-tests `tohost` word and the console byte address, and latches PASS, FAIL or TIMEOUT.
- Counts cycles and retired instructions, and drives `halt` back to the PC stage.
- Lets compliance benches stop on a real result instead of a fixed delay.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word.
- CONSOLE_ADDR, 32'h0000_1004, byte address of the console character register.
- MAX_CYCLES, 10000, watchdog limit in clock cycles while running.
- CNT_W, 32, width of the cycle and instret counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- st_en  input  1  store strobe from the core, same cycle as the dmem write enable
- st_addr  input  32  store byte address
- st_data  input  32  store write data
- retire  input  1  one-cycle pulse per retired instruction
- halt  output  1  high in any terminal state; core gates PC update with it
- pass  output  1  tohost written with 1
- fail  output  1  tohost written with an odd value other than 1
- timeout  output  1  watchdog expired
- fail_code  output  31  st_data[31:1] captured on fail (failing test number)
- cycle_cnt  output  CNT_W  cycles spent in RUN
- instret_cnt  output  CNT_W  retire pulses counted in RUN
- con_valid  output  1  one-cycle pulse: console byte available
- con_byte  output  8  console character, st_data[7:0]

Behaviour:
- Reset (async assert, sync release): state=RUN; all outputs 0; both counters 0.
- FSM states: RUN, PASS, FAIL, TMO. PASS, FAIL and TMO are terminal and sticky until rst.
- RUN transitions, evaluated on the edge sampling the store:
  - st_en && st_addr==TOHOST_ADDR && st_data==1 -> PASS.
  - st_en && st_addr==TOHOST_ADDR && st_data[0] && st_data!=1 -> FAIL, with fail_code<=st_data[31:1].
  - Store to tohost with st_data[0]==0 is ignored (syscall form, unsupported); stay in RUN.
  - Otherwise, if cycle_cnt==MAX_CYCLES-1 -> TMO.
- Priority on the same edge: a tohost decode beats watchdog expiry.
- Outputs are registered:
  - halt/pass/fail/timeout rise one cycle after the deciding store edge.
  - pass, fail and timeout are mutually exclusive. halt = pass|fail|timeout.
- Counters:
  - cycle_cnt increments every cycle in RUN.
  - instret_cnt increments on retire in RUN.
  - Both freeze on leaving RUN. Both wrap at 2^CNT_W (unreachable with the default MAX_CYCLES).
  - The deciding cycle is counted.
- Console:
  - st_en && st_addr==CONSOLE_ADDR in RUN gives con_valid=1 for exactly one cycle, next cycle, with con_byte=st_data[7:0].
  - con_byte holds its value between pulses.
  - Console stores in terminal states are ignored.
- Address compare is full 32-bit equality; stores to other addresses are ignored.
- The monitor never blocks or modifies the store; dmem still performs it.
- Ignore st_en when st_addr/st_data are X only in simulation; RTL has no X-checks.
- rst asserted mid-run returns everything to reset values immediately, regardless of state.

Decomposition:
- Shared header cpu_defs.vh: FSM state encodings (2-bit: RUN=0, PASS=1, FAIL=2, TMO=3) and the default TOHOST/CONSOLE addresses.
- No sub-module. The two counters are inline; a generic counter module would add nothing.

Test Plan:
- rst high 20 ns then low, no stores -> all outputs 0. With MAX_CYCLES=50, timeout=1 and halt=1 one cycle after cycle_cnt reaches 49. cycle_cnt then holds 50.
- Store 32'h1 to 32'h1000 at cycle 10 -> pass=1 and halt=1 at cycle 11. fail=0, timeout=0. cycle_cnt frozen at 11.
- Store 32'h7 to 32'h1000 -> fail=1 and fail_code=3. A following store of 32'h1 to 32'h1000 leaves pass=0 (sticky).
- Store 32'h2 to 32'h1000 -> state stays RUN, halt=0. Stores of 32'h48 then 32'h69 to 32'h1004 -> two con_valid pulses with con_byte 8'h48 then 8'h69.
- With MAX_CYCLES=20, tohost=1 stored on the edge where cycle_cnt==19 -> pass=1, timeout=0.
- After reaching PASS, pulse rst for 3 ns mid-cycle -> outputs and counters clear immediately (async). 7 retire pulses afterwards give instret_cnt=7.

Source files
------------

// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost/console store monitor: FSM encodings
// and the default riscv-tests mailbox addresses.
package tohost_monitor_pkg;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;
    localparam logic [1:0] ST_TMO  = 2'd3;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_1004;

    localparam int unsigned FAIL_CODE_W = 31;

    function automatic logic is_terminal(input logic [1:0] st);
        return st != ST_RUN;
    endfunction

endpackage

// File: rtl/tohost_monitor.sv
// Watches the data-memory store port for tohost/console writes, latches the
// compliance result (PASS/FAIL/TMO), counts cycles and retires, and halts the core.
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR  = DEFAULT_TOHOST_ADDR,
    parameter logic [31:0] CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR,
    parameter int unsigned MAX_CYCLES   = 10000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_en,
    input  logic [31:0]            st_addr,
    input  logic [31:0]            st_data,
    input  logic                   retire,
    output logic                   halt,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [FAIL_CODE_W-1:0] fail_code,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instret_cnt,
    output logic                   con_valid,
    output logic [7:0]             con_byte
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    logic [1:0]             state_q,     state_d;
    logic [FAIL_CODE_W-1:0] fail_code_q, fail_code_d;
    logic [CNT_W-1:0]       cycle_q,     cycle_d;
    logic [CNT_W-1:0]       instret_q,   instret_d;
    logic                   con_valid_q, con_valid_d;
    logic [7:0]             con_byte_q,  con_byte_d;
    logic                   halt_q, pass_q, fail_q, timeout_q;

    logic running;
    logic tohost_odd;
    logic console_hit;
    logic wd_expire;

    assign running     = !is_terminal(state_q);
    // Even tohost values are the syscall form and deliberately ignored.
    assign tohost_odd  = st_en && (st_addr == TOHOST_ADDR) && st_data[0];
    assign console_hit = st_en && (st_addr == CONSOLE_ADDR);
    assign wd_expire   = (cycle_q == WD_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        fail_code_d = fail_code_q;
        cycle_d     = cycle_q;
        instret_d   = instret_q;
        con_valid_d = 1'b0;
        con_byte_d  = con_byte_q;

        if (running) begin
            cycle_d   = cycle_q + CNT_W'(1);
            instret_d = instret_q + CNT_W'(retire);

            // A tohost result on the expiry edge wins over the watchdog.
            if (tohost_odd) begin
                if (st_data == 32'd1) begin
                    state_d = ST_PASS;
                end else begin
                    state_d     = ST_FAIL;
                    fail_code_d = st_data[31:1];
                end
            end else if (wd_expire) begin
                state_d = ST_TMO;
            end

            if (console_hit) begin
                con_valid_d = 1'b1;
                con_byte_d  = st_data[7:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            fail_code_q <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
            con_valid_q <= 1'b0;
            con_byte_q  <= 8'h00;
            halt_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
            con_valid_q <= con_valid_d;
            con_byte_q  <= con_byte_d;
            halt_q      <= is_terminal(state_d);
            pass_q      <= (state_d == ST_PASS);
            fail_q      <= (state_d == ST_FAIL);
            timeout_q   <= (state_d == ST_TMO);
        end
    end

    // Status flags are flopped directly so the core sees glitch-free halt.
    assign halt        = halt_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign fail_code   = fail_code_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign con_valid   = con_valid_q;
    assign con_byte    = con_byte_q;

endmodule
